// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-read-port register file with byte-strobed writes,
//            write-to-read bypass, optional hardwired-zero entry and a
//            sequential bulk-clear engine.
// Revision : 1.0
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W/8-1:0]        wr_be,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_err,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       clr_start,
    output logic                       clr_busy,
    output logic                       clr_done
);

    localparam int              c_DEPTH = 2**ADDR_W;
    localparam int              c_BYTES = DATA_W/8;
    localparam logic [ADDR_W:0] c_LAST  = (ADDR_W+1)'(c_DEPTH-1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W:0]     r_clrCnt;
    logic                r_wrErr;
    logic                r_clrDone;
    logic [DATA_W-1:0]   r_mem [c_DEPTH];

    logic                w_inClear;
    logic [ADDR_W-1:0]   w_clrAddr;
    logic                w_wrZero;
    logic                w_wrAccept;
    logic                w_lastEntry;
    logic [DATA_W-1:0]   w_wrMerged;

    assign w_inClear   = (r_state == S_CLEAR);
    assign w_clrAddr   = r_clrCnt[ADDR_W-1:0];
    assign w_wrZero    = (ZERO_REG != 0) && (wr_addr == '0);
    assign w_wrAccept  = wr_en && !w_inClear && !w_wrZero;
    assign w_lastEntry = w_inClear && (r_clrCnt == c_LAST);

    // Byte-merged write value, shared by the array update and the bypass path
    for (genvar b = 0; b < c_BYTES; b++) begin : g_byte
        assign w_wrMerged[b*8 +: 8] = wr_be[b] ? wr_data[b*8 +: 8] : r_mem[wr_addr][b*8 +: 8];
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (clr_start)   w_nextState = S_CLEAR;
            S_CLEAR: if (w_lastEntry) w_nextState = S_IDLE;
            default:                  w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_clrCnt  <= '0;
            r_wrErr   <= 1'b0;
            r_clrDone <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_wrErr   <= wr_en && w_inClear;
            r_clrDone <= w_lastEntry;
            if ((r_state == S_IDLE) && clr_start) begin
                r_clrCnt <= '0;
            end else if (w_inClear) begin
                r_clrCnt <= r_clrCnt + 1'b1;
            end
        end
    end

    // The sweep owns the array while busy; external writes are dropped then
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_inClear) begin
            r_mem[w_clrAddr] <= '0;
        end else if (w_wrAccept) begin
            r_mem[wr_addr] <= w_wrMerged;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_rdAddr;
        logic [DATA_W-1:0] r_rdData;

        assign w_rdAddr = rd_addr[p*ADDR_W +: ADDR_W];

        // Priority: zero entry, entry being swept, bypass, stored value
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_rdData <= '0;
            end else if (rd_en[p]) begin
                if ((ZERO_REG != 0) && (w_rdAddr == '0)) begin
                    r_rdData <= '0;
                end else if (w_inClear && (w_rdAddr == w_clrAddr)) begin
                    r_rdData <= '0;
                end else if ((BYPASS != 0) && w_wrAccept && (w_rdAddr == wr_addr)) begin
                    r_rdData <= w_wrMerged;
                end else begin
                    r_rdData <= r_mem[w_rdAddr];
                end
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = r_rdData;
    end

    assign wr_err   = r_wrErr;
    assign clr_busy = w_inClear;
    assign clr_done = r_clrDone;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Scoreboard bench for regfile_mp: directed writes/reads, bypass,
//            zero entry, bulk clear and reset during clear.
// Revision : 1.0
// ============================================================================
module tb_regfile_mp;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_RD   = 2;
    localparam int ZERO_REG = 1;
    localparam int BYPASS   = 1;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W/8-1:0]      wr_be;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_err;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     clr_start;
    logic                     clr_busy;
    logic                     clr_done;

    typedef struct {
        int                port;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              r_expQ[$];
    logic [NUM_RD-1:0] r_vld;
    int                errors = 0;
    int                checks = 0;

    regfile_mp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
        .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .wr_err(wr_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=%0h req=%0h", name, act, exp);
        end
    endtask

    // A port whose rd_en was high at an edge presents data after that edge
    always @(posedge clk or negedge reset) begin
        if (!reset) r_vld <= '0;
        else        r_vld <= rd_en;
    end

    always @(negedge clk) begin
        for (int p = 0; p < NUM_RD; p++) begin
            if (r_vld[p]) begin
                if (r_expQ.size() == 0) begin
                    check($sformatf("sb_empty_p%0d", p), 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = r_expQ.pop_front();
                    check($sformatf("sb_port_p%0d", p), 64'(e.port), 64'(p));
                    check($sformatf("rd_data_p%0d", p), 64'(rd_data[p*DATA_W +: DATA_W]), 64'(e.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        rd_en     = '0;
        wr_en     = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic rdSet(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
        rd_en[p] = 1'b1;
        rd_addr[p*ADDR_W +: ADDR_W] = a;
        r_expQ.push_back('{port: p, data: e});
    endtask

    task automatic wrSet(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [3:0] be);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
        rd_en = '0; rd_addr = '0; clr_start = 1'b0;
        step(); step();
        reset = 1'b1;
        #1;
        check("rst_busy", 64'(clr_busy), 64'd0);
        check("rst_done", 64'(clr_done), 64'd0);
        check("rst_wrerr", 64'(wr_err), 64'd0);
        check("rst_rddata", 64'(rd_data), 64'd0);

        for (int a = 0; a < 32; a++) begin
            rdSet(0, 5'(a), 32'h0);
            rdSet(1, 5'(31 - a), 32'h0);
            step();
        end

        // Byte-strobed writes
        wrSet(5'd3, 32'hAABBCCDD, 4'hF); step();
        wrSet(5'd3, 32'h11223344, 4'b0101); step();
        rdSet(0, 5'd3, 32'hAA22CC44); step();

        // Bypass: full word and partial strobe
        wrSet(5'd5, 32'hDEADBEEF, 4'hF);
        rdSet(1, 5'd5, (BYPASS != 0) ? 32'hDEADBEEF : 32'h0); step();
        wrSet(5'd3, 32'h00009900, 4'b0010);
        rdSet(0, 5'd3, (BYPASS != 0) ? 32'hAA229944 : 32'hAA22CC44);
        rdSet(1, 5'd5, 32'hDEADBEEF); step();

        // Zero entry ignores writes and wins over bypass
        wrSet(5'd0, 32'hFFFFFFFF, 4'hF); step();
        rdSet(0, 5'd0, 32'h0); rdSet(1, 5'd0, 32'h0); step();
        wrSet(5'd0, 32'h12345678, 4'hF);
        rdSet(0, 5'd0, 32'h0); step();

        // Fill 1..6 then sweep
        wrSet(5'd1, 32'h01010101, 4'hF); step();
        wrSet(5'd2, 32'h02020202, 4'hF); step();
        wrSet(5'd4, 32'h04040404, 4'hF); step();
        wrSet(5'd6, 32'h06060606, 4'hF); step();
        rdSet(0, 5'd6, 32'h06060606); rdSet(1, 5'd4, 32'h04040404); step();

        clr_start = 1'b1; step();
        for (int i = 0; i < 32; i++) begin
            check($sformatf("clr_busy_c%0d", i), 64'(clr_busy), 64'd1);
            check($sformatf("clr_done_c%0d", i), 64'(clr_done), 64'd0);
            check($sformatf("wr_err_c%0d", i), 64'(wr_err), (i == 11) ? 64'd1 : 64'd0);
            if (i == 2)  rdSet(1, 5'd6, 32'h06060606);
            if (i == 3)  rdSet(0, 5'd3, 32'h0);
            if (i == 10) wrSet(5'd7, 32'h77777777, 4'hF);
            if (i == 12) clr_start = 1'b1;
            step();
        end
        check("clr_end_busy", 64'(clr_busy), 64'd0);
        check("clr_end_done", 64'(clr_done), 64'd1);
        step();
        check("clr_done_pulse", 64'(clr_done), 64'd0);
        check("clr_no_restart", 64'(clr_busy), 64'd0);
        for (int a = 0; a < 8; a++) begin
            rdSet(0, 5'(a), 32'h0);
            rdSet(1, 5'(a + 8), 32'h0);
            step();
        end

        // Reset in the middle of a sweep
        wrSet(5'd9,  32'h99999999, 4'hF); step();
        wrSet(5'd20, 32'h20202020, 4'hF); step();
        rdSet(0, 5'd20, 32'h20202020); step();
        step();
        clr_start = 1'b1; step();
        for (int i = 0; i < 7; i++) step();
        check("mid_busy_before", 64'(clr_busy), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_busy_async", 64'(clr_busy), 64'd0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mid_no_done_%0d", i), 64'(clr_done), 64'd0);
            check($sformatf("mid_idle_%0d", i), 64'(clr_busy), 64'd0);
            step();
        end
        rdSet(0, 5'd9, 32'h0); rdSet(1, 5'd20, 32'h0); step();
        rdSet(0, 5'd5, 32'h0); step();

        step(); step();
        check("sb_drain", 64'(r_expQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
